// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative MIPS multiply/divide unit with HI/LO registers.
// Shift-add multiply and restoring divide run one bit per CALC cycle; FIX applies signs.
module mul_div_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ITER = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] src_a,
    input  logic [DATA_WIDTH-1:0] src_b,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);
    localparam int W = DATA_WIDTH;
    localparam int CW = $clog2(ITER + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [W-1:0]    opnd_q, hi_q, lo_q;
    logic [2*W-1:0]  acc_q;
    logic            sa_q, sb_q, div_q, div0_q, busy_q, done_q;

    logic            sa_d, sb_d, ge_d;
    logic [W-1:0]    a_mag_d, b_mag_d, q_d, r_d;
    logic [W:0]      sum_d, trial_d, diff_d;
    logic [2*W-1:0]  step_d, prod_d, res_d;

    // Unsigned ops (op[0]=1) have no sign, so magnitudes are the raw operands.
    always_comb begin
        sa_d    = ~op[0] & src_a[W-1];
        sb_d    = ~op[0] & src_b[W-1];
        a_mag_d = sa_d ? -src_a : src_a;
        b_mag_d = sb_d ? -src_b : src_b;
        sum_d   = {1'b0, acc_q[2*W-1:W]} + {1'b0, opnd_q & {W{acc_q[0]}}};
        trial_d = acc_q[2*W-1:W-1];
        diff_d  = trial_d - {1'b0, opnd_q};
        ge_d    = ~diff_d[W];
        step_d  = div_q ? {(ge_d ? diff_d[W-1:0] : trial_d[W-1:0]), acc_q[W-2:0], ge_d}
                        : {sum_d, acc_q[W-1:1]};
        prod_d  = (sa_q ^ sb_q) ? -acc_q : acc_q;
        q_d     = (sa_q ^ sb_q) ? -acc_q[W-1:0] : acc_q[W-1:0];
        r_d     = sa_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
        res_d   = div_q ? {r_d, q_d} : prod_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            opnd_q  <= '0;
            acc_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            div_q   <= 1'b0;
            div0_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && !op[2]) begin
                        state_q <= CALC;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        sa_q    <= sa_d;
                        sb_q    <= sb_d;
                        div_q   <= op[1];
                        div0_q  <= op[1] && (src_b == '0);
                        opnd_q  <= op[1] ? b_mag_d : a_mag_d;
                        acc_q   <= {{W{1'b0}}, (op[1] ? a_mag_d : b_mag_d)};
                    end else if (start && op == 3'b100) begin
                        hi_q <= src_a;
                    end else if (start && op == 3'b101) begin
                        lo_q <= src_a;
                    end
                end
                CALC: begin
                    acc_q <= step_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(ITER - 1)) state_q <= FIX;
                end
                FIX: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    if (!div0_q) {hi_q, lo_q} <= res_d;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed vectors for mul_div_unit with hand-computed results.
module tb_mul_div_unit;
    logic        clk, rst, start, busy, done;
    logic [2:0]  op;
    logic [31:0] src_a, src_b, hi, lo;
    int          total = 0, bad = 0;

    localparam logic [2:0] MULT = 3'b000, MULTU = 3'b001, DIV = 3'b010, DIVU = 3'b011;
    localparam logic [2:0] MTHI = 3'b100, MTLO = 3'b101;

    mul_div_unit dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at a negedge; drives one start cycle and returns at the next negedge.
    task automatic go(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1; op = o; src_a = a; src_b = b;
        @(negedge clk);
        start = 0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run(input string tag, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        int n;
        go(o, a, b);
        check({tag, "_busy"}, busy, 1);
        wait_done(n);
        check({tag, "_lat"}, n + 1, 34);
        check({tag, "_hi"}, hi, eh);
        check({tag, "_lo"}, lo, el);
        check({tag, "_busy_end"}, busy, 0);
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
    endtask

    initial begin
        int n;
        bit seen;
        rst = 0; start = 0; op = 0; src_a = 0; src_b = 0;
        #1;
        check("rst_state", {busy, done, hi, lo}, 0);
        @(negedge clk);
        rst = 1;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (busy || done) seen = 1;
        end
        check("idle_quiet", {seen, hi, lo}, 0);

        run("mult",  MULT,  32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE);
        run("multu", MULTU, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE);
        run("div",   DIV,   32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run("divu",  DIVU,  32'd100, 32'd7, 32'd2, 32'd14);
        run("div_ovf", DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
        run("mult_mix", MULT, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB);

        go(MTHI, 32'h1234, 32'h0);
        check("mthi", {busy, done, hi}, {2'b00, 32'h1234});
        go(MTLO, 32'h5678, 32'h0);
        check("mtlo", {busy, done, hi, lo}, {2'b00, 32'h1234, 32'h5678});
        go(3'b110, 32'hDEAD, 32'd3);
        check("reserved", {busy, hi, lo}, {1'b0, 32'h1234, 32'h5678});
        run("divu_zero", DIVU, 32'd55, 32'd0, 32'h1234, 32'h5678);

        go(MULTU, 32'd3, 32'd5);
        repeat (9) @(negedge clk);
        go(DIVU, 32'd100, 32'd7);
        check("ign_start_busy", busy, 1);
        go(MTHI, 32'hAAAA, 32'h0);
        check("ign_mthi", hi, 32'h1234);
        src_a = 32'd9; src_b = 32'd9;
        wait_done(n);
        check("ign_lat", n + 12, 34);
        check("ign_res", {hi, lo}, {32'd0, 32'd15});

        go(MULT, 32'hFFFFFFFD, 32'd4);
        check("b2b_busy", {busy, done}, 2'b10);
        wait_done(n);
        check("b2b_lat", n + 1, 34);
        check("b2b_res", {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFF4});

        @(negedge clk);
        go(MULT, 32'd5, 32'd6);
        repeat (19) @(negedge clk);
        rst = 0;
        #1;
        check("midrst", {busy, done, hi, lo}, 0);
        @(negedge clk);
        rst = 1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) seen = 1;
        end
        check("midrst_quiet", {seen, hi, lo}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative integer multiply/divide unit with architectural HI/LO registers for the single-cycle MIPS core.
- Sits directly downstream of the register file: operands come from the rs/rt read ports (rdata1/rdata2).
- Executes MULT, MULTU, DIV, DIVU in multiple cycles, and MTHI/MTLO in one cycle.
- The controller stalls on busy; hi/lo feed the MFHI/MFLO writeback path back into the register file.

Parameters:
- DATA_WIDTH, 32: operand and HI/LO width. Only 32 is supported; the FPGA 4-bit register-file build does not instantiate this unit.
- ITER, 32: iteration cycles in CALC. Must equal DATA_WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request strobe, sampled at rising edge.
- op  in  3  operation select: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110 and 111 are reserved.
- src_a  in  DATA_WIDTH  rs operand (multiplicand/dividend; MTHI/MTLO data).
- src_b  in  DATA_WIDTH  rt operand (multiplier/divisor).
- busy  out  1  high while an operation is in progress; the core must stall.
- done  out  1  one-cycle pulse when a mul/div result is committed.
- hi  out  DATA_WIDTH  HI register.
- lo  out  DATA_WIDTH  LO register.

Behaviour:
- Reset (rst=0, asynchronous, any state including mid-operation):
  - State goes to IDLE.
  - hi=0, lo=0, busy=0, done=0.
  - Iteration counter and internal operand registers are cleared.
  - Any in-flight operation is discarded.
- States:
  - IDLE -> CALC: at a rising edge with start=1 and op in 000..011.
  - CALC -> FIX: after exactly ITER edges in CALC.
  - FIX -> IDLE: after one edge.
- Latency:
  - Accept at edge k.
  - CALC iterates on edges k+1..k+32.
  - FIX commits hi/lo at edge k+33.
  - busy=1 between edges k and k+33. busy=0 and done=1 for exactly the one cycle following edge k+33.
  - done is 0 in all other cycles.
- Operand capture:
  - src_a/src_b are latched at accept; changes afterwards have no effect.
  - Signed ops (MULT/DIV) latch magnitudes plus the two sign bits.
- Multiply:
  - Shift-add, one multiplier bit per CALC cycle, giving a 64-bit unsigned product.
  - FIX negates the product if signs differ (signed only).
  - hi = product[63:32], lo = product[31:0].
- Divide:
  - Restoring division, one quotient bit per CALC cycle.
  - Quotient is negated if signs differ; remainder takes the dividend's sign (signed only).
  - lo = quotient, hi = remainder.
  - 0x80000000 / 0xFFFFFFFF (DIV) gives lo=0x80000000, hi=0.
- Divide by zero (src_b=0 at accept, DIV or DIVU):
  - Full latency still runs and done still pulses.
  - hi/lo are left unchanged.
- MTHI/MTLO:
  - Accepted only in IDLE. Write hi or lo at the same edge from src_a.
  - No busy, no done; the other register is unchanged.
- Ignored requests:
  - start while busy=1: no state change, in-flight operation unaffected.
  - Reserved op (110/111): ignored in all states.
  - start=0: nothing happens.
- Back-to-back: a new start is accepted in the cycle where done=1, since the state is IDLE.
- hi/lo hold their value during CALC and FIX; they change only at the FIX edge or at an MTHI/MTLO edge.

Test Plan:
- Reset then idle: rst=0 -> hi=0, lo=0, busy=0, done=0. Release; no start for 5 cycles -> outputs unchanged.
- MULT a=0xFFFFFFFF, b=2 -> busy for 33 cycles, then done pulse, hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100, b=7 -> lo=14, hi=2. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI 0x1234, then MTLO 0x5678 (one cycle each) -> hi=0x1234, lo=0x5678, done never asserted. Then DIVU b=0 -> done after 33 cycles, hi/lo still 0x1234/0x5678.
- MULTU 3*5 accepted; at cycle 10 issue start with op=DIVU and MTHI 0xAAAA -> both ignored; result hi=0, lo=15. Immediate start during the done cycle -> accepted, busy next cycle.
- MULT in flight: assert rst at cycle 20 -> busy=0, hi=lo=0 immediately. After release, no done pulse appears.
